// File: rtl/execute_stage.sv
// Execute stage of a 5-stage MIPS-style pipeline: operand forwarding, ALU, destination select,
// and the EX/MEM pipeline register. Every output is registered.
// Latency: one cycle, gated by i_enable. Stall by holding i_enable low; outputs hold their value.
// Reset (async, active-high) clears all outputs immediately.
//
// Ports:
//   i_clk, i_reset, i_enable              clock, async reset, pipeline-register load enable
//   i_instruccion                         instruction word ([10:6] shamt, [5:0] funct)
//   i_aluOP, i_aluSrc, i_regDst           ALU class, operand-B select, destination select
//   i_datoLeido1/2, i_datoExtSigno        rs/rt register data, sign-extended immediate
//   i_rt_id, i_rd_id, i_rs_id             register indices
//   i_rt_OR_rd, i_rd_EX_MEM, i_rd_MEM_WB  reserved, not used
//   i_opcode                              opcode, decoded for immediate-class ops
//   i_wbData, i_memData, i_forwardA/B     forwarding sources and selects
//   i_memToReg..i_branch                  control bits passed through to MEM
//   o_aluResult, o_ceroSignal             ALU result and its zero flag
//   o_datoLeido2                          forwarded rt data (store data)
//   o_rd_data                             rs index
//   o_rt_OR_rd                            destination register index
//   o_memToReg..o_branch                  registered control bits
module execute_stage #(
    parameter int N_BITS     = 32,
    parameter int N_REG_BITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [N_BITS-1:0]     i_instruccion,
    input  logic [1:0]            i_aluOP,
    input  logic                  i_aluSrc,
    input  logic                  i_regDst,
    input  logic [N_BITS-1:0]     i_datoLeido1,
    input  logic [N_BITS-1:0]     i_datoLeido2,
    input  logic [N_BITS-1:0]     i_datoExtSigno,
    input  logic [N_REG_BITS-1:0] i_rt_id,
    input  logic [N_REG_BITS-1:0] i_rd_id,
    input  logic [N_REG_BITS-1:0] i_rs_id,
    input  logic [N_REG_BITS-1:0] i_rt_OR_rd,
    input  logic [N_REG_BITS-1:0] i_rd_EX_MEM,
    input  logic [N_REG_BITS-1:0] i_rd_MEM_WB,
    input  logic [N_REG_BITS:0]   i_opcode,
    input  logic [N_BITS-1:0]     i_wbData,
    input  logic [N_BITS-1:0]     i_memData,
    input  logic [1:0]            i_forwardA,
    input  logic [1:0]            i_forwardB,
    input  logic                  i_memToReg,
    input  logic                  i_regWrite_EX_MEM,
    input  logic                  i_regWrite_MEM_WB,
    input  logic                  i_memWrite,
    input  logic                  i_memRead,
    input  logic [1:0]            i_branch,
    output logic [N_BITS-1:0]     o_aluResult,
    output logic                  o_ceroSignal,
    output logic [N_BITS-1:0]     o_datoLeido2,
    output logic [N_REG_BITS-1:0] o_rd_data,
    output logic [N_REG_BITS-1:0] o_rt_OR_rd,
    output logic                  o_memToReg,
    output logic                  o_regWrite_EX_MEM,
    output logic                  o_regWrite_MEM_WB,
    output logic                  o_memWrite,
    output logic                  o_memRead,
    output logic [1:0]            o_branch
);

    // ALU operation classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    // Immediate-class opcodes
    localparam logic [N_REG_BITS:0] OP_ADDI  = (N_REG_BITS+1)'(6'b001000);
    localparam logic [N_REG_BITS:0] OP_ADDIU = (N_REG_BITS+1)'(6'b001001);
    localparam logic [N_REG_BITS:0] OP_SLTI  = (N_REG_BITS+1)'(6'b001010);
    localparam logic [N_REG_BITS:0] OP_SLTIU = (N_REG_BITS+1)'(6'b001011);
    localparam logic [N_REG_BITS:0] OP_ANDI  = (N_REG_BITS+1)'(6'b001100);
    localparam logic [N_REG_BITS:0] OP_ORI   = (N_REG_BITS+1)'(6'b001101);
    localparam logic [N_REG_BITS:0] OP_XORI  = (N_REG_BITS+1)'(6'b001110);
    localparam logic [N_REG_BITS:0] OP_LUI   = (N_REG_BITS+1)'(6'b001111);

    logic [N_BITS-1:0] op_a;
    logic [N_BITS-1:0] fwd_b;
    logic [N_BITS-1:0] op_b;
    logic [N_BITS-1:0] imm_zext;
    logic [N_BITS-1:0] imm_upper;
    logic [N_BITS-1:0] alu_result;
    logic [4:0]        shamt;
    logic [4:0]        var_shamt;
    logic [5:0]        funct;
    logic              lt_signed;
    logic              lt_unsigned;
    logic [N_REG_BITS-1:0] dest_idx;

    // Reserved inputs and instruction bits above shamt are not needed here.
    logic unused_inputs;
    assign unused_inputs = ^{i_rt_OR_rd, i_rd_EX_MEM, i_rd_MEM_WB, i_instruccion[N_BITS-1:11]};

    assign shamt     = i_instruccion[10:6];
    assign funct     = i_instruccion[5:0];
    assign var_shamt = op_a[4:0];

    // Logical immediates use the raw 16-bit field, not the sign-extended copy.
    assign imm_zext  = {{(N_BITS-16){1'b0}}, i_datoExtSigno[15:0]};
    assign imm_upper = imm_zext << 16;

    // Forwarding muxes: 11 is unused by the hazard unit and falls back to register data.
    always_comb begin
        case (i_forwardA)
            2'b01:   op_a = i_wbData;
            2'b10:   op_a = i_memData;
            default: op_a = i_datoLeido1;
        endcase
    end

    always_comb begin
        case (i_forwardB)
            2'b01:   fwd_b = i_wbData;
            2'b10:   fwd_b = i_memData;
            default: fwd_b = i_datoLeido2;
        endcase
    end

    assign op_b = i_aluSrc ? i_datoExtSigno : fwd_b;

    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        alu_result = '0;
        case (i_aluOP)
            ALUOP_ADD: alu_result = op_a + op_b;
            ALUOP_SUB: alu_result = op_a - op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_result = op_a + op_b;
                    FN_SUB, FN_SUBU: alu_result = op_a - op_b;
                    FN_AND:  alu_result = op_a & op_b;
                    FN_OR:   alu_result = op_a | op_b;
                    FN_XOR:  alu_result = op_a ^ op_b;
                    FN_NOR:  alu_result = ~(op_a | op_b);
                    FN_SLT:  alu_result = {{(N_BITS-1){1'b0}}, lt_signed};
                    FN_SLTU: alu_result = {{(N_BITS-1){1'b0}}, lt_unsigned};
                    // Shifts operate on B; the amount comes from shamt or A[4:0].
                    FN_SLL:  alu_result = op_b << shamt;
                    FN_SRL:  alu_result = op_b >> shamt;
                    FN_SRA:  alu_result = $signed(op_b) >>> shamt;
                    FN_SLLV: alu_result = op_b << var_shamt;
                    FN_SRLV: alu_result = op_b >> var_shamt;
                    FN_SRAV: alu_result = $signed(op_b) >>> var_shamt;
                    default: alu_result = '0;
                endcase
            end
            ALUOP_ITYPE: begin
                case (i_opcode)
                    OP_ADDI, OP_ADDIU: alu_result = op_a + op_b;
                    OP_ANDI:  alu_result = op_a & imm_zext;
                    OP_ORI:   alu_result = op_a | imm_zext;
                    OP_XORI:  alu_result = op_a ^ imm_zext;
                    OP_LUI:   alu_result = imm_upper;
                    OP_SLTI:  alu_result = {{(N_BITS-1){1'b0}}, lt_signed};
                    OP_SLTIU: alu_result = {{(N_BITS-1){1'b0}}, lt_unsigned};
                    default:  alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    assign dest_idx = i_regDst ? i_rd_id : i_rt_id;

    // EX/MEM pipeline register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_aluResult       <= '0;
            o_ceroSignal      <= 1'b0;
            o_datoLeido2      <= '0;
            o_rd_data         <= '0;
            o_rt_OR_rd        <= '0;
            o_memToReg        <= 1'b0;
            o_regWrite_EX_MEM <= 1'b0;
            o_regWrite_MEM_WB <= 1'b0;
            o_memWrite        <= 1'b0;
            o_memRead         <= 1'b0;
            o_branch          <= 2'b00;
        end else if (i_enable) begin
            o_aluResult       <= alu_result;
            o_ceroSignal      <= (alu_result == '0);
            o_datoLeido2      <= fwd_b;
            o_rd_data         <= i_rs_id;
            o_rt_OR_rd        <= dest_idx;
            o_memToReg        <= i_memToReg;
            o_regWrite_EX_MEM <= i_regWrite_EX_MEM;
            o_regWrite_MEM_WB <= i_regWrite_MEM_WB;
            o_memWrite        <= i_memWrite;
            o_memRead         <= i_memRead;
            o_branch          <= i_branch;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [31:0] i_instruccion;
    logic [1:0]  i_aluOP;
    logic        i_aluSrc;
    logic        i_regDst;
    logic [31:0] i_datoLeido1, i_datoLeido2, i_datoExtSigno;
    logic [4:0]  i_rt_id, i_rd_id, i_rs_id;
    logic [4:0]  i_rt_OR_rd, i_rd_EX_MEM, i_rd_MEM_WB;
    logic [5:0]  i_opcode;
    logic [31:0] i_wbData, i_memData;
    logic [1:0]  i_forwardA, i_forwardB;
    logic        i_memToReg, i_regWrite_EX_MEM, i_regWrite_MEM_WB, i_memWrite, i_memRead;
    logic [1:0]  i_branch;

    logic [31:0] o_aluResult;
    logic        o_ceroSignal;
    logic [31:0] o_datoLeido2;
    logic [4:0]  o_rd_data, o_rt_OR_rd;
    logic        o_memToReg, o_regWrite_EX_MEM, o_regWrite_MEM_WB, o_memWrite, o_memRead;
    logic [1:0]  o_branch;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage #(.N_BITS(32), .N_REG_BITS(5)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
        .i_instruccion(i_instruccion), .i_aluOP(i_aluOP), .i_aluSrc(i_aluSrc),
        .i_regDst(i_regDst), .i_datoLeido1(i_datoLeido1), .i_datoLeido2(i_datoLeido2),
        .i_datoExtSigno(i_datoExtSigno), .i_rt_id(i_rt_id), .i_rd_id(i_rd_id),
        .i_rs_id(i_rs_id), .i_rt_OR_rd(i_rt_OR_rd), .i_rd_EX_MEM(i_rd_EX_MEM),
        .i_rd_MEM_WB(i_rd_MEM_WB), .i_opcode(i_opcode), .i_wbData(i_wbData),
        .i_memData(i_memData), .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
        .i_memToReg(i_memToReg), .i_regWrite_EX_MEM(i_regWrite_EX_MEM),
        .i_regWrite_MEM_WB(i_regWrite_MEM_WB), .i_memWrite(i_memWrite),
        .i_memRead(i_memRead), .i_branch(i_branch),
        .o_aluResult(o_aluResult), .o_ceroSignal(o_ceroSignal),
        .o_datoLeido2(o_datoLeido2), .o_rd_data(o_rd_data), .o_rt_OR_rd(o_rt_OR_rd),
        .o_memToReg(o_memToReg), .o_regWrite_EX_MEM(o_regWrite_EX_MEM),
        .o_regWrite_MEM_WB(o_regWrite_MEM_WB), .o_memWrite(o_memWrite),
        .o_memRead(o_memRead), .o_branch(o_branch)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [31:0] d2;
        logic [4:0]  rs;
        logic [4:0]  dst;
        logic [6:0]  ctl;
    } exp_t;

    exp_t exp_q = '0;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val,
                                         input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return reg_val;
    endfunction

    // Names the operation, then evaluates it with plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [1:0] aluop, input logic [31:0] instr,
                                            input logic [5:0] opc, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] ext);
        string op;
        int    sh;
        int    sb;
        op = "zero";
        sh = int'(instr[10:6]);
        if (aluop == 2'd0) op = "add";
        else if (aluop == 2'd1) op = "sub";
        else if (aluop == 2'd2) begin
            case (int'(instr[5:0]))
                32, 33: op = "add";
                34, 35: op = "sub";
                36: op = "and";   37: op = "or";    38: op = "xor";  39: op = "nor";
                42: op = "slt";   43: op = "sltu";
                0:  op = "sll";   2:  op = "srl";   3:  op = "sra";
                4:  begin op = "sll"; sh = int'(a % 32); end
                6:  begin op = "srl"; sh = int'(a % 32); end
                7:  begin op = "sra"; sh = int'(a % 32); end
                default: op = "zero";
            endcase
        end else begin
            case (int'(opc))
                8, 9: op = "add";
                12: op = "andi";  13: op = "ori";   14: op = "xori";  15: op = "lui";
                10: op = "slt";   11: op = "sltu";
                default: op = "zero";
            endcase
        end
        sb = int'(b);
        case (op)
            "add":  return a + b;
            "sub":  return a - b;
            "and":  return a & b;
            "or":   return a | b;
            "xor":  return a ^ b;
            "nor":  return ~(a | b);
            "slt":  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            "sltu": return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            "sll":  return b << sh;
            "srl":  return b >> sh;
            "sra":  return 32'(sb >>> sh);
            "andi": return a & (ext % 65536);
            "ori":  return a | (ext % 65536);
            "xori": return a ^ (ext % 65536);
            "lui":  return (ext % 65536) * 65536;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge i_clk or posedge i_reset) begin
        exp_t e;
        logic [31:0] a, fb, b;
        if (i_reset) begin
            exp_q <= '0;
        end else if (i_enable) begin
            a  = pick(i_forwardA, i_datoLeido1, i_wbData, i_memData);
            fb = pick(i_forwardB, i_datoLeido2, i_wbData, i_memData);
            b  = i_aluSrc ? i_datoExtSigno : fb;
            e.res  = ref_alu(i_aluOP, i_instruccion, i_opcode, a, b, i_datoExtSigno);
            e.zero = (e.res == 32'd0);
            e.d2   = fb;
            e.rs   = i_rs_id;
            e.dst  = i_regDst ? i_rd_id : i_rt_id;
            e.ctl  = {i_memToReg, i_regWrite_EX_MEM, i_regWrite_MEM_WB, i_memWrite, i_memRead, i_branch};
            exp_q <= e;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] dut_ctl();
        return {o_memToReg, o_regWrite_EX_MEM, o_regWrite_MEM_WB, o_memWrite, o_memRead, o_branch};
    endfunction

    // Compare process: every falling edge, DUT against the model.
    always @(negedge i_clk) begin
        check("cmp_result", o_aluResult, exp_q.res);
        check("cmp_zero", 32'(o_ceroSignal), 32'(exp_q.zero));
        check("cmp_dato2", o_datoLeido2, exp_q.d2);
        check("cmp_rs", 32'(o_rd_data), 32'(exp_q.rs));
        check("cmp_dst", 32'(o_rt_OR_rd), 32'(exp_q.dst));
        check("cmp_ctl", 32'(dut_ctl()), 32'(exp_q.ctl));
    end

    // ---------------- directed stimulus ----------------
    task automatic base();
        i_enable = 1'b1; i_instruccion = '0; i_aluOP = 2'd0; i_aluSrc = 1'b0; i_regDst = 1'b0;
        i_datoLeido1 = '0; i_datoLeido2 = '0; i_datoExtSigno = '0;
        i_rt_id = '0; i_rd_id = '0; i_rs_id = '0;
        i_rt_OR_rd = 5'd31; i_rd_EX_MEM = 5'd31; i_rd_MEM_WB = 5'd31;
        i_opcode = '0; i_wbData = '0; i_memData = '0; i_forwardA = '0; i_forwardB = '0;
        i_memToReg = 0; i_regWrite_EX_MEM = 0; i_regWrite_MEM_WB = 0; i_memWrite = 0;
        i_memRead = 0; i_branch = '0;
    endtask

    task automatic tick_expect(input string name, input logic [31:0] req);
        @(posedge i_clk);
        #1;
        check(name, o_aluResult, req);
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        base();
        i_aluOP = 2'd2; i_instruccion = {21'd0, sh, fn};
        i_datoLeido1 = a; i_datoLeido2 = b;
    endtask

    task automatic itype(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] ext);
        base();
        i_aluOP = 2'd3; i_opcode = opc; i_aluSrc = 1'b1;
        i_datoLeido1 = a; i_datoExtSigno = ext;
    endtask

    initial begin
        base();
        i_reset = 1'b1;
        #1;
        check("reset_result", o_aluResult, 32'd0);
        check("reset_zero", 32'(o_ceroSignal), 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;

        rtype(6'h21, 5'd0, 32'd1, 32'd3);
        tick_expect("addu", 32'd4);
        check("addu_zero", 32'(o_ceroSignal), 32'd0);

        rtype(6'h21, 5'd0, 32'd1, 32'd3);
        i_forwardA = 2'b01; i_forwardB = 2'b10; i_wbData = 32'd5; i_memData = 32'd6;
        tick_expect("fwd_add", 32'd11);
        check("fwd_dato2", o_datoLeido2, 32'd6);

        base(); i_aluOP = 2'd1; i_datoLeido1 = 32'd7; i_datoLeido2 = 32'd7;
        tick_expect("sub_zero", 32'd0);
        check("sub_zero_flag", 32'(o_ceroSignal), 32'd1);

        base(); i_aluSrc = 1'b1; i_datoExtSigno = 32'h10; i_datoLeido1 = 32'd1;
        tick_expect("add_imm", 32'h11);

        rtype(6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1);
        tick_expect("slt", 32'd1);
        rtype(6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1);
        tick_expect("sltu", 32'd0);
        rtype(6'h03, 5'd4, 32'd0, 32'h8000_0000);
        tick_expect("sra", 32'hF800_0000);
        rtype(6'h00, 5'd4, 32'd0, 32'h0000_00F1);
        tick_expect("sll", 32'h0000_0F10);
        rtype(6'h06, 5'd0, 32'h24, 32'hF0);
        tick_expect("srlv", 32'h0000_000F);
        rtype(6'h27, 5'd0, 32'hF0F0_F0F0, 32'h0F0F_0000);
        tick_expect("nor", 32'h0000_0F0F);
        rtype(6'h3F, 5'd0, 32'd9, 32'd9);
        tick_expect("undecoded", 32'd0);
        check("undecoded_zero", 32'(o_ceroSignal), 32'd1);

        itype(6'h0F, 32'd0, 32'h0000_ABCD);
        tick_expect("lui", 32'hABCD_0000);
        itype(6'h0C, 32'hFFFF_00FF, 32'hFFFF_8F0F);
        tick_expect("andi", 32'h0000_000F);
        itype(6'h0A, 32'hFFFF_FFFB, 32'hFFFF_FFFE);
        tick_expect("slti", 32'd1);
        itype(6'h3E, 32'd5, 32'd5);
        tick_expect("undecoded_op", 32'd0);

        base(); i_forwardA = 2'b11; i_datoLeido1 = 32'd2; i_datoLeido2 = 32'd3; i_wbData = 32'd100;
        tick_expect("fwd11", 32'd5);

        // Destination select and control pass-through
        base(); i_regDst = 1'b1; i_rd_id = 5'd3; i_rt_id = 5'd2; i_rs_id = 5'd9;
        i_datoLeido1 = 32'd20; i_datoLeido2 = 32'd22;
        i_memToReg = 1; i_regWrite_MEM_WB = 1; i_memRead = 1; i_branch = 2'b10;
        tick_expect("ctl_add", 32'd42);
        check("dst_rd", 32'(o_rt_OR_rd), 32'd3);
        check("rs_idx", 32'(o_rd_data), 32'd9);
        check("ctl_bits", 32'(dut_ctl()), 32'b1010110);
        i_regDst = 1'b0;
        tick_expect("ctl_add2", 32'd42);
        check("dst_rt", 32'(o_rt_OR_rd), 32'd2);

        // Hold with enable low
        base(); i_enable = 1'b0; i_datoLeido1 = 32'd1000; i_rt_id = 5'd17; i_memWrite = 1;
        tick_expect("hold_result", 32'd42);
        check("hold_dst", 32'(o_rt_OR_rd), 32'd2);
        check("hold_ctl", 32'(dut_ctl()), 32'b1010110);

        // Asynchronous reset between edges
        #3;
        i_reset = 1'b1;
        #1;
        check("areset_result", o_aluResult, 32'd0);
        check("areset_dst", 32'(o_rt_OR_rd), 32'd0);
        check("areset_ctl", 32'(dut_ctl()), 32'd0);
        base(); i_datoLeido1 = 32'd8; i_datoLeido2 = 32'd8; i_memRead = 1;
        tick_expect("reset_priority", 32'd0);
        check("reset_priority_ctl", 32'(dut_ctl()), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        tick_expect("first_load", 32'd16);
        check("first_load_ctl", 32'(dut_ctl()), 32'b0000100);

        @(negedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
